// File: rtl/axis_frame_len_check.sv
// rtl/axis_frame_len_check.sv - AXI-Stream frame length checker: tags runts, truncates oversize frames.
// Optional AXIS_FRAME_LEN_CHECK_PAD_EN: zero-pad good runt frames up to MIN_LEN instead of marking them bad.
module axis_frame_len_check #(
  parameter int DATA_WIDTH = 8,
  parameter int USER_WIDTH = 1,
  parameter int LEN_WIDTH = 16,
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518,
  parameter logic [USER_WIDTH-1:0] USER_BAD_FRAME_VALUE = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  output logic                  status_good_frame,
  output logic                  status_bad_frame,
  output logic                  status_oversize,
  output logic                  status_undersize
);

  localparam logic [LEN_WIDTH-1:0] MIN_L = LEN_WIDTH'(MIN_LEN);
  localparam logic [LEN_WIDTH-1:0] MAX_L = LEN_WIDTH'(MAX_LEN);

  typedef enum logic [1:0] {
    ST_TRANSFER,
    ST_DISCARD
`ifdef AXIS_FRAME_LEN_CHECK_PAD_EN
    , ST_PAD
`endif
  } state_t;

  state_t                state_q, state_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d, beat_num;
  logic                  tready_q, s_fire, hold_in;
  logic                  in_valid, in_last;
  logic [DATA_WIDTH-1:0] in_data;
  logic [USER_WIDTH-1:0] in_user;
  logic                  over_d, under_d;

  logic                  m_valid_q, m_last_q, skid_valid_q, skid_last_q, skid_valid_d;
  logic [DATA_WIDTH-1:0] m_data_q, skid_data_q;
  logic [USER_WIDTH-1:0] m_user_q, skid_user_q;
  logic                  out_ready, m_fire;
  logic                  good_q, bad_q, over_q, under_q;

  assign s_fire    = s_axis_tvalid && tready_q;
  assign beat_num  = cnt_q + LEN_WIDTH'(1);
  assign out_ready = m_axis_tready || !m_valid_q;
  assign m_fire    = m_valid_q && m_axis_tready;

  // Frame-length FSM: decides what (if anything) enters the output stage this cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    in_valid = 1'b0;
    in_data  = s_axis_tdata;
    in_last  = s_axis_tlast;
    in_user  = s_axis_tuser;
    over_d   = 1'b0;
    under_d  = 1'b0;
    unique case (state_q)
      ST_TRANSFER: begin
        if (s_fire) begin
          in_valid = 1'b1;
          cnt_d    = beat_num;
          if (s_axis_tlast) begin
            cnt_d = '0;
            if (beat_num < MIN_L) begin
              under_d = 1'b1;
`ifdef AXIS_FRAME_LEN_CHECK_PAD_EN
              if (s_axis_tuser != USER_BAD_FRAME_VALUE) begin
                in_last = 1'b0;
                cnt_d   = beat_num;
                state_d = ST_PAD;
              end else begin
                in_user = USER_BAD_FRAME_VALUE;
              end
`else
              in_user = USER_BAD_FRAME_VALUE;
`endif
            end
          end else if (beat_num == MAX_L) begin
            in_last = 1'b1;
            in_user = USER_BAD_FRAME_VALUE;
            over_d  = 1'b1;
            cnt_d   = '0;
            state_d = ST_DISCARD;
          end
        end
      end
      ST_DISCARD: begin
        if (s_fire && s_axis_tlast) state_d = ST_TRANSFER;
      end
`ifdef AXIS_FRAME_LEN_CHECK_PAD_EN
      ST_PAD: begin
        // Only generate a pad beat when the skid slot is free to absorb a stall.
        if (!skid_valid_q) begin
          in_valid = 1'b1;
          in_data  = '0;
          in_user  = '0;
          in_last  = (beat_num == MIN_L);
          cnt_d    = beat_num;
          if (beat_num == MIN_L) begin
            cnt_d   = '0;
            state_d = ST_TRANSFER;
          end
        end
      end
`endif
      default: state_d = ST_TRANSFER;
    endcase
  end

  always_comb begin
    skid_valid_d = out_ready ? (skid_valid_q && in_valid) : (skid_valid_q || in_valid);
`ifdef AXIS_FRAME_LEN_CHECK_PAD_EN
    hold_in = (state_d == ST_PAD);
`else
    hold_in = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_TRANSFER;
      cnt_q        <= '0;
      tready_q     <= 1'b0;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      m_last_q     <= 1'b0;
      m_user_q     <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_last_q  <= 1'b0;
      skid_user_q  <= '0;
      good_q       <= 1'b0;
      bad_q        <= 1'b0;
      over_q       <= 1'b0;
      under_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tready_q     <= !skid_valid_d && !hold_in;
      skid_valid_q <= skid_valid_d;
      if (out_ready) begin
        if (skid_valid_q) begin
          m_valid_q <= 1'b1;
          m_data_q  <= skid_data_q;
          m_last_q  <= skid_last_q;
          m_user_q  <= skid_user_q;
        end else begin
          m_valid_q <= in_valid;
          if (in_valid) begin
            m_data_q <= in_data;
            m_last_q <= in_last;
            m_user_q <= in_user;
          end
        end
      end
      if (in_valid && (skid_valid_q || !out_ready)) begin
        skid_data_q <= in_data;
        skid_last_q <= in_last;
        skid_user_q <= in_user;
      end
      good_q  <= m_fire && m_last_q && (m_user_q != USER_BAD_FRAME_VALUE);
      bad_q   <= m_fire && m_last_q && (m_user_q == USER_BAD_FRAME_VALUE);
      over_q  <= over_d;
      under_q <= under_d;
    end
  end

  assign s_axis_tready     = tready_q;
  assign m_axis_tvalid     = m_valid_q;
  assign m_axis_tdata      = m_data_q;
  assign m_axis_tlast      = m_last_q;
  assign m_axis_tuser      = m_user_q;
  assign status_good_frame = good_q;
  assign status_bad_frame  = bad_q;
  assign status_oversize   = over_q;
  assign status_undersize  = under_q;

endmodule

// File: tb/tb_axis_frame_len_check.sv
// tb/tb_axis_frame_len_check.sv - table-driven bench for axis_frame_len_check with model scoreboard.
`timescale 1ns/1ps
module tb_axis_frame_len_check;
  localparam int MIN_LEN = 64;
  localparam int MAX_LEN = 1518;
`ifdef AXIS_FRAME_LEN_CHECK_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] s_axis_tdata = '0;
  logic       s_axis_tvalid = 1'b0;
  logic       s_axis_tready;
  logic       s_axis_tlast = 1'b0;
  logic [0:0] s_axis_tuser = '0;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready = 1'b1;
  logic       m_axis_tlast;
  logic [0:0] m_axis_tuser;
  logic       status_good_frame, status_bad_frame, status_oversize, status_undersize;

  always #5 clk = ~clk;

  axis_frame_len_check dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .status_good_frame(status_good_frame), .status_bad_frame(status_bad_frame),
    .status_oversize(status_oversize), .status_undersize(status_undersize)
  );

  typedef struct packed {logic [7:0] d; logic l; logic u;} beat_t;
  typedef struct {
    int len; bit bad; bit gaps; bit rr;
    int exp_beats; int exp_lu; int eg; int eb; int eo; int eu;
  } vec_t;

  beat_t exp_q[$];
  beat_t got_q[$];
  int n_good, n_bad, n_over, n_under;
  int n_checks = 0;
  int n_pass = 0;
  bit rand_rdy = 1'b0;

  // Output monitor: picks m_axis_tready, then records the beat that the next edge will take.
  initial forever begin
    @(negedge clk);
    m_axis_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    if (m_axis_tvalid && m_axis_tready) got_q.push_back({m_axis_tdata, m_axis_tlast, m_axis_tuser[0]});
    if (status_good_frame) n_good++;
    if (status_bad_frame)  n_bad++;
    if (status_oversize)   n_over++;
    if (status_undersize)  n_under++;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic wait_accept();
    int t = 0;
    while (!s_axis_tready && t < 5000) begin @(negedge clk); t++; end
    if (t >= 5000) begin
      n_checks++;
      $display("FAIL accept_timeout: s_axis_tready got 0, expected 1");
    end
    @(negedge clk);
  endtask

  task automatic send_frame(input int len, input bit bad, input bit gaps, input logic [7:0] seed,
                            input int start, input bit do_last);
    for (int i = start; i < len; i++) begin
      if (gaps && ($urandom_range(0, 2) == 0)) begin
        s_axis_tvalid = 1'b0;
        @(negedge clk);
      end
      s_axis_tdata  = seed + 8'(i);
      s_axis_tvalid = 1'b1;
      s_axis_tlast  = do_last && (i == len - 1);
      s_axis_tuser  = (do_last && (i == len - 1)) ? bad : 1'b0;
      wait_accept();
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = '0;
  endtask

  // Reference model of the output beats for one frame.
  task automatic build_exp(input int len, input bit bad, input logic [7:0] seed);
    beat_t b;
    int n;
    bit pad;
    n   = (len > MAX_LEN) ? MAX_LEN : len;
    pad = PAD && (len < MIN_LEN) && !bad;
    for (int i = 0; i < n; i++) begin
      b.d = seed + 8'(i);
      b.l = (i == n - 1) && !pad;
      b.u = (i == n - 1) && !pad && ((len > MAX_LEN) || (len < MIN_LEN) || bad);
      exp_q.push_back(b);
    end
    if (pad) begin
      for (int i = n; i < MIN_LEN; i++) begin
        b.d = 8'h00;
        b.l = (i == MIN_LEN - 1);
        b.u = 1'b0;
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic begin_vec();
    exp_q.delete();
    got_q.delete();
    n_good = 0; n_bad = 0; n_over = 0; n_under = 0;
  endtask

  task automatic finish_vec(input string name, input int exp_beats, input int exp_lu,
                            input int eg, input int eb, input int eo, input int eu);
    int t = 0;
    int bad_idx = -1;
    int n;
    while (got_q.size() < exp_q.size() && t < 20000) begin @(negedge clk); t++; end
    repeat (4) @(negedge clk);
    chk({name, "_beats"}, got_q.size(), exp_beats);
    chk({name, "_last_user"}, (got_q.size() > 0) ? int'(got_q[got_q.size()-1].u) : -1, exp_lu);
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      if (bad_idx < 0 && got_q[i] != exp_q[i]) bad_idx = i;
    chk({name, "_first_bad_beat_idx"}, bad_idx, -1);
    chk({name, "_good_pulses"}, n_good, eg);
    chk({name, "_bad_pulses"}, n_bad, eb);
    chk({name, "_oversize_pulses"}, n_over, eo);
    chk({name, "_undersize_pulses"}, n_under, eu);
  endtask

  initial begin
    vec_t vt[13];
    int rg, rb, ro, ru;
    vt[0]  = '{1518, 0, 0, 0, 1518, 0, 1, 0, 0, 0};
    vt[1]  = '{1600, 0, 0, 0, 1518, 1, 0, 1, 1, 0};
    vt[2]  = '{100,  0, 0, 0, 100,  0, 1, 0, 0, 0};
    vt[3]  = '{10,   0, 0, 0, PAD ? 64 : 10, PAD ? 0 : 1, PAD ? 1 : 0, PAD ? 0 : 1, 0, 1};
    vt[4]  = '{1,    0, 0, 0, PAD ? 64 : 1,  PAD ? 0 : 1, PAD ? 1 : 0, PAD ? 0 : 1, 0, 1};
    vt[5]  = '{64,   0, 0, 0, 64,   0, 1, 0, 0, 0};
    vt[6]  = '{63,   0, 0, 0, PAD ? 64 : 63, PAD ? 0 : 1, PAD ? 1 : 0, PAD ? 0 : 1, 0, 1};
    vt[7]  = '{1519, 0, 0, 0, 1518, 1, 0, 1, 1, 0};
    vt[8]  = '{100,  1, 0, 0, 100,  1, 0, 1, 0, 0};
    vt[9]  = '{10,   1, 0, 0, 10,   1, 0, 1, 0, 1};
    vt[10] = '{1600, 1, 0, 0, 1518, 1, 0, 1, 1, 0};
    vt[11] = '{200,  0, 1, 1, 200,  0, 1, 0, 0, 0};
    vt[12] = '{20,   0, 1, 1, PAD ? 64 : 20, PAD ? 0 : 1, PAD ? 1 : 0, PAD ? 0 : 1, 0, 1};

    repeat (3) @(negedge clk);
    chk("rst_m_tvalid", m_axis_tvalid, 0);
    chk("rst_m_tdata", m_axis_tdata, 0);
    chk("rst_m_tlast", m_axis_tlast, 0);
    chk("rst_m_tuser", m_axis_tuser, 0);
    chk("rst_s_tready", s_axis_tready, 0);
    chk("rst_status", {status_good_frame, status_bad_frame, status_oversize, status_undersize}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_s_tready", s_axis_tready, 1);

    // 100-beat frame with an explicit one-cycle latency probe on the first beat.
    begin_vec();
    build_exp(100, 1'b0, 8'h10);
    chk("lat_idle_m_tvalid", m_axis_tvalid, 0);
    chk("lat_s_tready", s_axis_tready, 1);
    s_axis_tdata  = 8'h10;
    s_axis_tvalid = 1'b1;
    @(negedge clk);
    chk("lat_m_tvalid", m_axis_tvalid, 1);
    chk("lat_m_tdata", m_axis_tdata, 8'h10);
    send_frame(100, 1'b0, 1'b0, 8'h10, 1, 1'b1);
    finish_vec("f100", 100, 0, 1, 0, 0, 0);

    for (int k = 0; k < 13; k++) begin
      begin_vec();
      rand_rdy = vt[k].rr;
      build_exp(vt[k].len, vt[k].bad, 8'(k * 37));
      send_frame(vt[k].len, vt[k].bad, vt[k].gaps, 8'(k * 37), 0, 1'b1);
      finish_vec($sformatf("vec%0d_len%0d", k, vt[k].len), vt[k].exp_beats, vt[k].exp_lu,
                 vt[k].eg, vt[k].eb, vt[k].eo, vt[k].eu);
    end

    // Reset at beat 30 of a 100-beat frame, then a 70-beat frame.
    rand_rdy = 1'b0;
    begin_vec();
    send_frame(30, 1'b0, 1'b0, 8'h33, 0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_m_tvalid", m_axis_tvalid, 0);
    chk("midrst_s_tready", s_axis_tready, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    begin_vec();
    build_exp(70, 1'b0, 8'h44);
    send_frame(70, 1'b0, 1'b0, 8'h44, 0, 1'b1);
    finish_vec("rst30_then70", 70, 0, 1, 0, 0, 0);

    // Reset deep into a long frame: the beat counter must restart at 1.
    begin_vec();
    send_frame(1500, 1'b0, 1'b0, 8'h55, 0, 1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    begin_vec();
    build_exp(100, 1'b0, 8'h66);
    send_frame(100, 1'b0, 1'b0, 8'h66, 0, 1'b1);
    finish_vec("rst1500_then100", 100, 0, 1, 0, 0, 0);

    // 200 random frames, random output stalls and input gaps, against the model.
    begin_vec();
    rand_rdy = 1'b1;
    rg = 0; rb = 0; ro = 0; ru = 0;
    for (int f = 0; f < 200; f++) begin
      int len;
      bit bad;
      len = (f % 50 == 49) ? $urandom_range(1517, 1520) : $urandom_range(1, 120);
      bad = ($urandom_range(0, 3) == 0);
      build_exp(len, bad, 8'(f * 7));
      if (len > MAX_LEN) ro++;
      if (len < MIN_LEN) ru++;
      if ((len > MAX_LEN) || bad || (len < MIN_LEN && !PAD)) rb++;
      else rg++;
      send_frame(len, bad, 1'b1, 8'(f * 7), 0, 1'b1);
    end
    finish_vec("random200", exp_q.size(), exp_q[exp_q.size()-1].u, rg, rb, ro, ru);
    rand_rdy = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
